// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_pkg
//  Description : Shared FSM state encodings and default operand width for
//                the bit-serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    localparam int c_default_width = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_subtractor_pkg
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : start/done handshake and operand/result bundle for the
//                bit-serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = c_default_width
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    // Requester side: drives the operation request, observes the result.
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    // Subtractor side.
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor
//  Description : One-bit combinational full subtractor, a - b - bin.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  wire logic a,
    input  wire logic b,
    input  wire logic bin,
    output logic      f_diff,
    output logic      f_borrow
);
    // Borrow when b exceeds a, or when a==b and a borrow is coming in.
    assign f_diff   = a ^ b ^ bin;
    assign f_borrow = (~a & b) | (~(a ^ b) & bin);
endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial LSB-first subtractor, diff = a - b - bin over
//                WIDTH cycles with a single full-subtractor cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_subtractor_if.slave bus
);
    localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic               w_d;
    logic               w_br_next;

    full_subtractor u_fs (
        .a        (r_a_sr[0]),
        .b        (r_b_sr[0]),
        .bin      (r_br),
        .f_diff   (w_d),
        .f_borrow (w_br_next)
    );

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;

    // Control FSM plus serial datapath; result bits enter at the MSB and
    // walk down so the LSB lands in bit 0 after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.b;
                        r_br    <= bus.bin;
                        r_cnt   <= '0;
                        r_diff  <= '0;
                        r_bout  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_br   <= w_br_next;
                    if (r_cnt == c_last) begin
                        // Final bit: publish the borrow-out alongside done.
                        r_bout  <= w_br_next;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Directed self-checking bench for serial_subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation; returns one cycle after done, so a following
    // call lands its start on the earliest accepting edge.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                          input logic [3:0] ed, input logic eb, input string tag);
        int k;
        bus.a = a; bus.b = b; bus.bin = bi; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, ".busy_acc"}, 32'(bus.busy), 32'd1);
        k = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check({tag, ".latency"}, k, WIDTH);
        check({tag, ".diff"}, 32'(bus.diff), 32'(ed));
        check({tag, ".bout"}, 32'(bus.bout), 32'(eb));
        check({tag, ".busy_done"}, 32'(bus.busy), 32'd1);
        tick();
        check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
        check({tag, ".diff_hold"}, 32'(bus.diff), 32'(ed));
    endtask

    initial begin
        int          ndone;
        logic [3:0]  dv;
        logic        bv;
        logic [4:0]  r;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        tick(); tick();
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.diff", 32'(bus.diff), 32'd0);
        check("rst.bout", 32'(bus.bout), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic cases with hand-computed results.
        run_op(4'h9, 4'h3, 1'b0, 4'h6, 1'b0, "t1");
        tick(); tick(); tick();
        check("t1.idle_diff", 32'(bus.diff), 32'h6);
        check("t1.idle_bout", 32'(bus.bout), 32'd0);
        run_op(4'h3, 4'h9, 1'b0, 4'hA, 1'b1, "t2");
        run_op(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, "t3a");
        run_op(4'hF, 4'hF, 1'b0, 4'h0, 1'b0, "t3b");

        // Start pulsed mid-operation with new operands must be ignored.
        bus.a = 4'h9; bus.b = 4'h3; bus.bin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        bus.a = 4'h1; bus.b = 4'h1; bus.bin = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ndone = 0; dv = '0; bv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) begin
                ndone++;
                dv = bus.diff;
                bv = bus.bout;
            end
            tick();
        end
        check("t4.done_count", ndone, 1);
        check("t4.diff", 32'(dv), 32'h6);
        check("t4.bout", 32'(bv), 32'd0);
        check("t4.idle_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a shift sequence.
        bus.a = 4'hF; bus.b = 4'h0; bus.bin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check("t5.partial_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5.rst_busy", 32'(bus.busy), 32'd0);
        check("t5.rst_done", 32'(bus.done), 32'd0);
        check("t5.rst_diff", 32'(bus.diff), 32'd0);
        check("t5.rst_bout", 32'(bus.bout), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(4'h9, 4'h3, 1'b0, 4'h6, 1'b0, "t5.after");

        // Full operand sweep, back-to-back at earliest accept.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    r = {1'b0, 4'(ai)} - {1'b0, 4'(bi)} - 5'(ci);
                    run_op(4'(ai), 4'(bi), 1'(ci), r[3:0], r[4], "sweep");
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_serial_subtractor
`default_nettype wire
